// File: rtl/alu_exec_mem_pkg.sv
// Shared constants for the execute/memory slice: ALU control codes, ALU op
// encodings, R-type funct codes and memory-access opcodes.
package alu_exec_mem_pkg;

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100
  } alu_ctrl_e;

  localparam logic [5:0] ALUOP_ADD   = 6'b000000;
  localparam logic [5:0] ALUOP_SUB   = 6'b000001;
  localparam logic [5:0] ALUOP_RTYPE = 6'b000010;
  localparam logic [5:0] ALUOP_AND   = 6'b000011;
  localparam logic [5:0] ALUOP_OR    = 6'b000100;
  localparam logic [5:0] ALUOP_SLT   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Little-endian byte lane k occupies word bits [8k+7:8k].
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] offset);
    byte_lane = word[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/alu_exec_mem_if.sv
// Datapath bundle between the decode stage and the execute/memory slice.
interface alu_exec_mem_if;
  logic [5:0]  funct;
  logic [5:0]  alu_op;
  logic [5:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        overflow;
  logic        zero;
  logic [31:0] data_out;

  modport master (
    output funct, alu_op, opcode, a, b, write_data, mem_write, mem_read,
    input  alu_ctrl, alu_out, overflow, zero, data_out
  );

  modport slave (
    input  funct, alu_op, opcode, a, b, write_data, mem_write, mem_read,
    output alu_ctrl, alu_out, overflow, zero, data_out
  );
endinterface

// File: rtl/alu_exec_mem_dmem.sv
// Word-organised data memory with byte-lane stores, sign/zero-extended byte
// loads and an asynchronous clear on reset.
module alu_exec_mem_dmem
  import alu_exec_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [5:0]  opcode,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic [7:0]       byte_s;
  logic             unused_addr_s;

  // Upper address bits simply wrap onto the array.
  assign idx_s         = addr[IDX_W+1:2];
  assign unused_addr_s = ^addr[31:IDX_W+2];
  assign byte_s        = byte_lane(mem_r[idx_s], addr[1:0]);

  // Array update: asynchronous clear wins over any store on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (mem_write) begin
      if (opcode == OP_SB) begin
        mem_r[idx_s][{addr[1:0], 3'b000} +: 8] <= write_data[7:0];
      end else begin
        mem_r[idx_s] <= write_data;
      end
    end
  end

  // Load path: reads the array as it stands, so a same-cycle store is seen only after the edge.
  always_comb begin
    data_out = 32'h0000_0000;
    if (mem_read) begin
      case (opcode)
        OP_LB:   data_out = {{24{byte_s[7]}}, byte_s};
        OP_LBU:  data_out = {24'h00_0000, byte_s};
        default: data_out = mem_r[idx_s];
      endcase
    end else begin
      data_out = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/alu_exec_mem.sv
// Execute/memory slice: ALU-control decode, 32-bit ALU with zero/overflow
// flags, and the data memory addressed by the ALU result.
module alu_exec_mem
  import alu_exec_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input logic           clk,
  input logic           rst,
  alu_exec_mem_if.slave bus
);

  alu_ctrl_e   ctrl_s;
  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic [31:0] result_s;
  logic        ovf_s;

  // ALU-control decode from main-control op and R-type funct.
  always_comb begin
    ctrl_s = CTRL_ADD;
    case (bus.alu_op)
      ALUOP_ADD: ctrl_s = CTRL_ADD;
      ALUOP_SUB: ctrl_s = CTRL_SUB;
      ALUOP_AND: ctrl_s = CTRL_AND;
      ALUOP_OR:  ctrl_s = CTRL_OR;
      ALUOP_SLT: ctrl_s = CTRL_SLT;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl_s = CTRL_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl_s = CTRL_SUB;
          FUNCT_AND:             ctrl_s = CTRL_AND;
          FUNCT_OR:              ctrl_s = CTRL_OR;
          FUNCT_NOR:             ctrl_s = CTRL_NOR;
          FUNCT_SLT:             ctrl_s = CTRL_SLT;
          default:               ctrl_s = CTRL_ADD;
        endcase
      end
      default: ctrl_s = CTRL_ADD;
    endcase
  end

  assign sum_s  = bus.a + bus.b;
  assign diff_s = bus.a - bus.b;

  // ALU datapath; overflow only ever reported for signed ADD/SUB.
  always_comb begin
    result_s = 32'h0000_0000;
    ovf_s    = 1'b0;
    case (ctrl_s)
      CTRL_AND: result_s = bus.a & bus.b;
      CTRL_OR:  result_s = bus.a | bus.b;
      CTRL_NOR: result_s = ~(bus.a | bus.b);
      CTRL_SLT: result_s = {31'h0000_0000, ($signed(bus.a) < $signed(bus.b))};
      CTRL_ADD: begin
        result_s = sum_s;
        ovf_s    = (bus.a[31] == bus.b[31]) && (sum_s[31] != bus.a[31]);
      end
      CTRL_SUB: begin
        result_s = diff_s;
        ovf_s    = (bus.a[31] != bus.b[31]) && (diff_s[31] != bus.a[31]);
      end
      default: begin
        result_s = 32'h0000_0000;
        ovf_s    = 1'b0;
      end
    endcase
  end

  assign bus.alu_ctrl = ctrl_s;
  assign bus.alu_out  = result_s;
  assign bus.overflow = ovf_s;
  assign bus.zero     = (result_s == 32'h0000_0000);

  alu_exec_mem_dmem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk        (clk),
    .rst        (rst),
    .addr       (result_s),
    .write_data (bus.write_data),
    .opcode     (bus.opcode),
    .mem_write  (bus.mem_write),
    .mem_read   (bus.mem_read),
    .data_out   (bus.data_out)
  );

endmodule

// File: tb/tb_alu_exec_mem.sv
// Self-checking bench for alu_exec_mem: directed cases plus randomized traffic
// compared against a byte-addressed behavioural model.
module tb_alu_exec_mem;
  import alu_exec_mem_pkg::*;

  localparam int DEPTH  = 256;
  localparam int NBYTES = 4 * DEPTH;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] ref_mem [NBYTES];

  alu_exec_mem_if bus ();

  alu_exec_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [5:0] aop, input logic [5:0] fn);
    case (aop)
      6'd0: return 4'b0010;
      6'd1: return 4'b0110;
      6'd3: return 4'b0000;
      6'd4: return 4'b0001;
      6'd5: return 4'b0111;
      6'd2: begin
        case (fn)
          6'b100000, 6'b100001: return 4'b0010;
          6'b100010, 6'b100011: return 4'b0110;
          6'b100100:            return 4'b0000;
          6'b100101:            return 4'b0001;
          6'b100111:            return 4'b1100;
          6'b101010:            return 4'b0111;
          default:              return 4'b0010;
        endcase
      end
      default: return 4'b0010;
    endcase
  endfunction

  // Signed results computed in 64-bit arithmetic; overflow = out of 32-bit range.
  task automatic ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = 64'sd0;
    res = 32'h0;
    ovf = 1'b0;
    case (c)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b);
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0010: begin s = sa + sb; res = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
      4'b0110: begin s = sa - sb; res = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
      default: res = 32'h0;
    endcase
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [5:0] op, input logic rd);
    int unsigned ba   = addr % NBYTES;
    int unsigned base = ba - (ba % 4);
    logic [7:0] bv = ref_mem[ba];
    if (!rd) return 32'h0;
    if (op == 6'b100000) return {{24{bv[7]}}, bv};
    if (op == 6'b100100) return {24'h0, bv};
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [5:0] op, input logic [31:0] wd);
    int unsigned ba   = addr % NBYTES;
    int unsigned base = ba - (ba % 4);
    if (op == 6'b101000) ref_mem[ba] = wd[7:0];
    else for (int k = 0; k < 4; k++) ref_mem[base + k] = wd[8*k +: 8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive(input logic [5:0] aop, input logic [5:0] fn, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                       input logic mw, input logic mr);
    bus.alu_op = aop; bus.funct = fn; bus.opcode = op;
    bus.a = a; bus.b = b; bus.write_data = wd;
    bus.mem_write = mw; bus.mem_read = mr;
  endtask

  task automatic check_all(input string tag);
    logic [3:0]  c;
    logic [31:0] res;
    logic        ovf;
    c = ref_ctrl(bus.alu_op, bus.funct);
    ref_alu(c, bus.a, bus.b, res, ovf);
    check({tag, ".ctrl"}, {28'h0, bus.alu_ctrl}, {28'h0, c});
    check({tag, ".out"},  bus.alu_out, res);
    check({tag, ".ovf"},  {31'h0, bus.overflow}, {31'h0, ovf});
    check({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, (res == 32'h0)});
    check({tag, ".dout"}, bus.data_out, ref_load(res, bus.opcode, bus.mem_read));
  endtask

  // Clock edge with model update: store only commits while reset is low.
  task automatic step_edge();
    logic [31:0] res;
    logic        ovf;
    @(posedge clk);
    if (bus.mem_write && !rst) begin
      ref_alu(ref_ctrl(bus.alu_op, bus.funct), bus.a, bus.b, res, ovf);
      ref_store(res, bus.opcode, bus.write_data);
    end
    #1;
  endtask

  logic [5:0] funct_list [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [5:0] op_list [5] = '{6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b101000};

  initial begin
    rst = 1'b1;
    ref_clear();
    drive(6'b000010, 6'b100000, 6'b100011, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1);
    #2;
    check_all("reset_alu");
    check("reset_dout", bus.data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed ALU cases
    drive(6'b000010, 6'b100000, 6'b100011, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0); #1;
    check_all("radd");
    check("radd_val", bus.alu_out, 32'd12);
    drive(6'b000001, 6'b000000, 6'b100011, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0); #1;
    check_all("sub_eq");
    check("sub_eq_zero", {31'h0, bus.zero}, 32'd1);
    drive(6'b000000, 6'b000000, 6'b100011, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0); #1;
    check_all("add_ovf");
    check("add_ovf_flag", {31'h0, bus.overflow}, 32'd1);
    drive(6'b000010, 6'b101010, 6'b100011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0); #1;
    check_all("slt");
    drive(6'b000010, 6'b100111, 6'b100011, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
    check_all("nor");
    drive(6'b000010, 6'b100100, 6'b100011, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0); #1;
    check_all("and");
    check("and_val", bus.alu_out, 32'h0000_00F0);

    // Word store / load
    @(negedge clk);
    drive(6'b000000, 6'b000000, 6'b101011, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step_edge();
    @(negedge clk);
    drive(6'b000000, 6'b000000, 6'b100011, 32'd8, 32'd0, 32'h0, 1'b0, 1'b1); #1;
    check_all("lw8");
    check("lw8_val", bus.data_out, 32'hDEAD_BEEF);
    bus.mem_read = 1'b0; #1;
    check("lw8_noread", bus.data_out, 32'h0);

    // Byte store / loads with aliasing
    @(negedge clk);
    drive(6'b000000, 6'b000000, 6'b101000, 32'h0D, 32'd0, 32'h0000_0080, 1'b1, 1'b0);
    step_edge();
    @(negedge clk);
    drive(6'b000000, 6'b000000, 6'b100011, 32'h0C, 32'd0, 32'h0, 1'b0, 1'b1); #1;
    check("sb_word", bus.data_out, 32'h0000_8000);
    drive(6'b000000, 6'b000000, 6'b100000, 32'h0D, 32'd0, 32'h0, 1'b0, 1'b1); #1;
    check("lb", bus.data_out, 32'hFFFF_FF80);
    bus.opcode = 6'b100100; #1;
    check("lbu", bus.data_out, 32'h0000_0080);
    drive(6'b000000, 6'b000000, 6'b100000, 32'h0D + 4 * DEPTH, 32'd0, 32'h0, 1'b0, 1'b1); #1;
    check("lb_alias", bus.data_out, 32'hFFFF_FF80);

    // Reset pulse between edges clears memory
    @(negedge clk);
    drive(6'b000000, 6'b000000, 6'b101011, 32'd4, 32'd0, 32'h1234_5678, 1'b1, 1'b1);
    step_edge();
    check("fill4", bus.data_out, 32'h1234_5678);
    @(negedge clk);
    bus.mem_write = 1'b0;
    rst = 1'b1; #1;
    ref_clear();
    check("rst_during", bus.data_out, 32'h0);
    #1 rst = 1'b0; #1;
    check("rst_after", bus.data_out, 32'h0);

    // Store edge while reset held is suppressed
    @(negedge clk);
    rst = 1'b1;
    drive(6'b000000, 6'b000000, 6'b101011, 32'd4, 32'd0, 32'hCAFE_F00D, 1'b1, 1'b1);
    step_edge();
    check("rst_store", bus.data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_write = 1'b0; #1;
    check("rst_store_after", bus.data_out, 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      logic [5:0]  aop, fn, op;
      logic [31:0] a, b;
      @(negedge clk);
      aop = 6'($urandom_range(0, 7));
      fn  = ($urandom_range(0, 9) < 8) ? funct_list[$urandom_range(0, 7)] : 6'($urandom);
      op  = ($urandom_range(0, 5) < 5) ? op_list[$urandom_range(0, 4)] : 6'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        aop = 6'd0;
        a   = $urandom_range(0, 2047);
        b   = $urandom_range(0, 15);
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      end
      drive(aop, fn, op, a, b, $urandom, 1'($urandom), 1'($urandom));
      #1;
      check_all($sformatf("rnd%0d_pre", it));
      step_edge();
      check_all($sformatf("rnd%0d_post", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_mem.md
# alu_exec_mem

Execute/memory slice of the single-cycle MIPS-style datapath. It decodes the ALU operation from the main-control ALU op and the instruction funct field, and computes the 32-bit ALU result with zero and overflow flags. It also hosts the data memory, addressed by the ALU result. Its outputs feed the write-back mux (memory data vs. ALU result) and the PC branch logic (zero flag).

## Interface
- DEPTH_WORDS, 256: data memory depth in 32-bit words; power of two.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- funct  in  6  instruction bits [5:0].
- alu_op  in  6  ALU op from main control.
- opcode  in  6  instruction opcode; selects word/byte memory access.
- a  in  32  ALU operand A (register read 1).
- b  in  32  ALU operand B (register read 2 or extended immediate).
- write_data  in  32  store data (register read 2).
- mem_write  in  1  store enable.
- mem_read  in  1  load enable.
- alu_ctrl  out  4  decoded ALU control code.
- alu_out  out  32  ALU result; also the memory byte address.
- overflow  out  1  signed overflow on ADD/SUB.
- zero  out  1  high when alu_out == 0.
- data_out  out  32  load data.

## Operation
- **ALU control codes:** AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- **alu_op decode:**
  - 000000 → ADD (lw/sw/addi).
  - 000001 → SUB (beq/bne).
  - 000010 → R-type, decoded by funct.
  - 000011 → AND (andi).
  - 000100 → OR (ori).
  - 000101 → SLT (slti).
  - any other value → ADD.
- **R-type funct decode:** 100000/100001 → ADD; 100010/100011 → SUB; 100100 → AND; 100101 → OR; 100111 → NOR; 101010 → SLT; any other funct → ADD.
- **ALU:**
  - SLT is signed compare; result is 1 or 0, zero-extended.
  - Any unlisted control code gives alu_out = 0.
  - Arithmetic is mod 2^32.
  - overflow: ADD sets it when both operands share a sign and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from a. overflow is 0 for all other codes.
  - zero is computed from alu_out for every code.
- **Memory organisation:**
  - Array of DEPTH_WORDS 32-bit words.
  - Word index = alu_out[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (address wraps).
  - Little-endian byte lanes: byte offset alu_out[1:0] selects bits [8*k+7:8*k].
- **Stores** (mem_write=1):
  - opcode 101000 (sb) writes only the addressed byte lane with write_data[7:0].
  - Any other opcode writes the full word; alu_out[1:0] is ignored.
- **Loads** (mem_read=1):
  - opcode 100000 (lb): addressed byte, sign-extended.
  - opcode 100100 (lbu): addressed byte, zero-extended.
  - any other opcode: full word.
  - mem_read=0 → data_out = 0.
- **mem_read and mem_write both high:** both operations proceed. The read returns pre-write contents until the clock edge.

## Timing
- alu_ctrl, alu_out, overflow, zero: purely combinational, zero latency.
- data_out: combinational read of the current array contents.
- Store commits at the rising clk edge when mem_write=1 and rst=0. Data is visible on data_out in the same cycle immediately after that edge.
- rst asserted:
  - All memory words clear to 0 immediately, independent of clk.
  - Writes are suppressed while rst is high.
  - data_out therefore reads 0 during and after reset until the first store.
- Reset outputs:
  - alu_ctrl, alu_out, overflow, zero remain combinational functions of the inputs; reset does not gate them.
  - data_out = 0.
- Reset mid-store: a rst edge coinciding with a clk edge wins; nothing is written.

## Structure
- Shared package holds:
  - ALU control code constants.
  - alu_op encodings.
  - funct codes.
  - Memory opcodes (lw 100011, sw 101011, lb 100000, lbu 100100, sb 101000).
- Top-level logic: ALU-control decoder and ALU.
- One sub-module: alu_exec_mem_dmem (memory array with byte-lane write and load extension).

## Test plan
- **R-type ADD:** alu_op=000010, funct=100000, a=5, b=7 → alu_ctrl=0010, alu_out=12, zero=0, overflow=0.
- **Subtract flags:**
  - alu_op=000001, a=b=0x1234 → alu_ctrl=0110, alu_out=0, zero=1.
  - a=0x7FFFFFFF, b=0x00000001 with ADD → alu_out=0x80000000, overflow=1.
- **Logic and SLT:**
  - funct=101010, a=0xFFFFFFFF (−1), b=1 → alu_out=1.
  - funct=100111, a=b=0 → alu_out=0xFFFFFFFF.
  - funct=100100, a=0xF0F0, b=0x0FF0 → alu_out=0x00F0.
- **Word store/load:**
  - Store 0xDEADBEEF via sw to address 8 at a clk edge.
  - Next cycle, lw from address 8 with mem_read=1 → data_out=0xDEADBEEF.
  - Same address with mem_read=0 → data_out=0.
- **Byte access:**
  - sb of 0x80 to address 0x0D over word 0x00000000 → word becomes 0x00008000.
  - lb address 0x0D → 0xFFFFFF80; lbu → 0x00000080.
  - Address 0x0D + 4·DEPTH_WORDS aliases the same byte.
- **Reset:**
  - Fill address 4, then pulse rst between clk edges → lw address 4 returns 0.
  - A store whose clk edge falls while rst=1 leaves memory at 0.
